// File: rtl/pim_tile_dispatcher_if.sv
// Dispatcher bus bundle: launch control, shared-memory read port and PIM local-memory write port.
interface pim_tile_dispatcher_if #(
    parameter int unsigned NUM_OF_PIM_UNITS = 4,
    parameter int unsigned WIDTH            = 32,
    parameter int unsigned LEN              = 10
);
    logic                        start;
    logic [LEN-1:0]              a_base;
    logic [LEN-1:0]              b_base;
    logic                        busy;
    logic                        done;
    logic                        mem_rd;
    logic [LEN-1:0]              mem_addr;
    logic                        mem_gnt;
    logic [WIDTH-1:0]            mem_rdata;
    logic [NUM_OF_PIM_UNITS-1:0] pim_we;
    logic [LEN-1:0]              pim_waddr;
    logic [WIDTH-1:0]            pim_wdata;

    modport master (
        input  start, a_base, b_base, mem_gnt, mem_rdata,
        output busy, done, mem_rd, mem_addr, pim_we, pim_waddr, pim_wdata
    );

    modport slave (
        output start, a_base, b_base, mem_gnt, mem_rdata,
        input  busy, done, mem_rd, mem_addr, pim_we, pim_waddr, pim_wdata
    );
endinterface

// File: rtl/pim_tile_dispatcher.sv
// Streams A then B out of shared memory row-major and broadcasts each word to the
// PIM units whose C tile needs it (A row-strips by tile row, B column-strips by tile column).
module pim_tile_dispatcher #(
    parameter int unsigned NUM_OF_PIM_UNITS = 4,
    parameter int unsigned MATRIX_SIZE      = 8,
    parameter int unsigned CHUNK_SIZE       = 4,
    parameter int unsigned WIDTH            = 32,
    parameter int unsigned LEN              = 10,
    parameter int unsigned B_LOCAL_OFFSET   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    pim_tile_dispatcher_if.master bus
);
    localparam int unsigned GRID = MATRIX_SIZE / CHUNK_SIZE;
    localparam int unsigned IW   = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(MATRIX_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_B  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                      state_q;
    state_t                      state_d;
    logic [IW-1:0]               row_q;
    logic [IW-1:0]               col_q;
    logic [LEN-1:0]              b_base_q;
    logic                        accept_c;
    logic                        last_c;
    logic                        is_b_c;
    int unsigned                 row_i;
    int unsigned                 col_i;
    logic [NUM_OF_PIM_UNITS-1:0] we_c;
    logic [LEN-1:0]              waddr_c;

    assign accept_c = bus.mem_rd & bus.mem_gnt;
    assign last_c   = (row_q == LAST_IDX) && (col_q == LAST_IDX);
    assign is_b_c   = (state_q == RD_B);
    assign row_i    = 32'(row_q);
    assign col_i    = 32'(col_q);

    // Read data is passed straight through; only enable and address are registered.
    assign bus.pim_wdata = bus.mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Return latency is fixed at one cycle, so DRAIN only covers the last write-back.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RD_A;
            RD_A:    if (accept_c && last_c) state_d = RD_B;
            RD_B:    if (accept_c && last_c) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Unit u = rb*GRID+cb takes A rows of strip rb and B columns of strip cb.
    for (genvar gu = 0; gu < NUM_OF_PIM_UNITS; gu++) begin : g_we
        assign we_c[gu] = is_b_c ? ((gu % GRID) == (col_i / CHUNK_SIZE))
                                 : ((gu / GRID) == (row_i / CHUNK_SIZE));
    end

    assign waddr_c = is_b_c
        ? LEN'(B_LOCAL_OFFSET + row_i * CHUNK_SIZE + (col_i % CHUNK_SIZE))
        : LEN'((row_i % CHUNK_SIZE) * MATRIX_SIZE + col_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q         <= '0;
            col_q         <= '0;
            b_base_q      <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.mem_rd    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.pim_we    <= '0;
            bus.pim_waddr <= '0;
        end else begin
            bus.busy   <= (state_d != IDLE);
            bus.done   <= (state_d == DONE);
            bus.mem_rd <= (state_d == RD_A) || (state_d == RD_B);
            bus.pim_we <= accept_c ? we_c : '0;

            if (state_q == IDLE && bus.start) begin
                bus.mem_addr <= bus.a_base;
                b_base_q     <= bus.b_base;
                row_q        <= '0;
                col_q        <= '0;
            end else if (accept_c) begin
                bus.pim_waddr <= waddr_c;
                // Elements are contiguous, so the address just increments (wrapping at 2^LEN).
                bus.mem_addr  <= (last_c && !is_b_c) ? b_base_q : bus.mem_addr + LEN'(1);
                if (col_q == LAST_IDX) begin
                    col_q <= '0;
                    row_q <= (row_q == LAST_IDX) ? '0 : row_q + IW'(1);
                end else begin
                    col_q <= col_q + IW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_pim_tile_dispatcher.sv
// Randomized bench: shared-memory responder plus a scoreboard of expected reads and
// write-backs built from the tile-ownership rules.
module tb_pim_tile_dispatcher;
    localparam int NU   = 4;
    localparam int N    = 8;
    localparam int CH   = 4;
    localparam int GRID = 2;
    localparam int W    = 32;
    localparam int L    = 10;
    localparam int BOFF = 32;
    localparam int NE   = N * N;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pim_tile_dispatcher_if #(.NUM_OF_PIM_UNITS(NU), .WIDTH(W), .LEN(L)) bus ();

    pim_tile_dispatcher #(
        .NUM_OF_PIM_UNITS(NU), .MATRIX_SIZE(N), .CHUNK_SIZE(CH),
        .WIDTH(W), .LEN(L), .B_LOCAL_OFFSET(BOFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run = 0;
    int tests_failed = 0;
    int cycle = 0;

    logic [W-1:0]  mem [1024];
    logic [NU-1:0] exp_we_q[$];
    logic [L-1:0]  exp_waddr_q[$];
    logic [W-1:0]  exp_data_q[$];
    logic [L-1:0]  exp_raddr_q[$];

    logic [NU-1:0] obs_we    [2*NE];
    logic [L-1:0]  obs_waddr [2*NE];
    logic [W-1:0]  obs_wdata [2*NE];
    logic [L-1:0]  obs_raddr [2*NE];
    int nwrites, naccepts, done_count, done_cycle, last_acc_cycle;

    logic          pend = 1'b0;
    logic [W-1:0]  pend_data = '0;
    logic          stalled = 1'b0;
    logic [L-1:0]  stall_addr = '0;
    logic          rst_v = 1'b1;
    logic [L-1:0]  ab_v = '0;
    logic [L-1:0]  bb_v = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // Expected traffic for one run: every element once, owners found by scanning tile ranges.
    task automatic build_expect(input logic [L-1:0] ab, input logic [L-1:0] bb);
        exp_we_q.delete(); exp_waddr_q.delete(); exp_data_q.delete(); exp_raddr_q.delete();
        nwrites = 0; naccepts = 0; done_count = 0; done_cycle = 0; last_acc_cycle = 0;
        for (int k = 0; k < 2*NE; k++) begin
            obs_we[k] = '0; obs_waddr[k] = '0; obs_wdata[k] = '0; obs_raddr[k] = '0;
        end
        for (int m = 0; m < 2; m++) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    logic [L-1:0]  a;
                    logic [NU-1:0] we;
                    int            la;
                    a  = L'(32'((m == 0) ? ab : bb) + r*N + c);
                    we = '0;
                    for (int rb = 0; rb < GRID; rb++)
                        for (int cb = 0; cb < GRID; cb++)
                            if ((m == 0) ? (r >= rb*CH && r < (rb+1)*CH)
                                         : (c >= cb*CH && c < (cb+1)*CH))
                                we = we | (NU'(1) << (rb*GRID + cb));
                    la = (m == 0) ? (r % CH) * N + c : BOFF + r * CH + (c % CH);
                    exp_raddr_q.push_back(a);
                    exp_we_q.push_back(we);
                    exp_waddr_q.push_back(L'(la));
                    exp_data_q.push_back(mem[a]);
                end
            end
        end
    endtask

    task automatic observe();
        if (bus.pim_we != '0) begin
            if (exp_we_q.size() == 0) begin
                check_eq("unexpected_write", 64'(bus.pim_we), 0);
            end else begin
                check_eq("pim_we", 64'(bus.pim_we), 64'(exp_we_q.pop_front()));
                check_eq("pim_waddr", 64'(bus.pim_waddr), 64'(exp_waddr_q.pop_front()));
                check_eq("pim_wdata", 64'(bus.pim_wdata), 64'(exp_data_q.pop_front()));
                if (nwrites < 2*NE) begin
                    obs_we[nwrites] = bus.pim_we;
                    obs_waddr[nwrites] = bus.pim_waddr;
                    obs_wdata[nwrites] = bus.pim_wdata;
                end
                nwrites++;
            end
        end
        if (stalled) begin
            check_eq("stall_rd_held", 64'(bus.mem_rd), 1);
            check_eq("stall_addr_held", 64'(bus.mem_addr), 64'(stall_addr));
        end
        if (bus.mem_rd && bus.mem_gnt) begin
            if (exp_raddr_q.size() == 0) check_eq("unexpected_read", 64'(bus.mem_rd), 0);
            else check_eq("mem_addr", 64'(bus.mem_addr), 64'(exp_raddr_q.pop_front()));
            if (naccepts < 2*NE) obs_raddr[naccepts] = bus.mem_addr;
            naccepts++;
            pend = 1'b1;
            pend_data = mem[bus.mem_addr];
            last_acc_cycle = cycle;
        end
        stalled = bus.mem_rd && !bus.mem_gnt && !rst_v;
        stall_addr = bus.mem_addr;
        if (bus.done) begin
            done_count++;
            done_cycle = cycle;
        end
    endtask

    // One clock: drive inputs just after the edge, sample outputs shortly after.
    task automatic tick(input logic st, input logic gnt);
        @(posedge clk);
        #1;
        cycle++;
        rst = rst_v;
        bus.start = st;
        bus.a_base = ab_v;
        bus.b_base = bb_v;
        bus.mem_gnt = gnt;
        bus.mem_rdata = pend ? pend_data : W'($urandom);
        pend = 1'b0;
        #1;
        observe();
    endtask

    // gmode: 0 grant always, 1 grant toggling 1,0,1..., 2 random grant.
    task automatic run_test(input logic [L-1:0] ab, input logic [L-1:0] bb,
                            input int gmode, input logic poke);
        int   t0;
        logic g;
        build_expect(ab, bb);
        ab_v = ab;
        bb_v = bb;
        tick(1'b1, 1'b1);
        t0 = cycle;
        check_eq("busy_before_start", 64'(bus.busy), 0);
        check_eq("done_before_start", 64'(bus.done), 0);
        for (int i = 1; i <= 700 && done_count == 0; i++) begin
            case (gmode)
                0:       g = 1'b1;
                1:       g = (i % 2 == 1);
                default: g = ($urandom_range(0, 3) != 0);
            endcase
            if (poke && i == 40) begin
                ab_v = ~ab;
                bb_v = ~bb;
            end
            tick(poke && i == 40, g);
            if (i == 1) begin
                check_eq("busy_rise", 64'(bus.busy), 1);
                check_eq("first_rd", 64'(bus.mem_rd), 1);
                check_eq("first_addr", 64'(bus.mem_addr), 64'(ab));
            end
        end
        check_eq("done_seen", 64'(done_count), 1);
        check_eq("write_count", 64'(nwrites), 64'(2*NE));
        check_eq("busy_at_done", 64'(bus.busy), 1);
        case (gmode)
            0:       check_eq("done_latency", 64'(done_cycle - t0), 130);
            1:       check_eq("done_latency", 64'(done_cycle - t0), 257);
            default: check_eq("done_after_last_read", 64'(done_cycle - last_acc_cycle), 2);
        endcase
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, 1'b1);
            check_eq("idle_busy", 64'(bus.busy), 0);
            check_eq("idle_done", 64'(bus.done), 0);
            check_eq("idle_rd", 64'(bus.mem_rd), 0);
        end
    endtask

    initial begin
        logic [L-1:0] wrap_exp [6];
        rst = 1'b1;
        bus.start = 1'b0;
        bus.a_base = '0;
        bus.b_base = '0;
        bus.mem_gnt = 1'b0;
        bus.mem_rdata = '0;
        for (int i = 0; i < 1024; i++) mem[i] = W'(i);

        rst_v = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        rst_v = 1'b0;
        tick(1'b0, 1'b1);
        check_eq("rst_busy", 64'(bus.busy), 0);
        check_eq("rst_done", 64'(bus.done), 0);
        check_eq("rst_mem_rd", 64'(bus.mem_rd), 0);
        check_eq("rst_mem_addr", 64'(bus.mem_addr), 0);
        check_eq("rst_pim_we", 64'(bus.pim_we), 0);
        check_eq("rst_pim_waddr", 64'(bus.pim_waddr), 0);
        idle_ticks(2);

        // Identity memory: specific broadcast targets and addresses.
        run_test(10'd0, 10'd64, 0, 1'b0);
        check_eq("a52_we", 64'(obs_we[42]), 64'hC);
        check_eq("a52_waddr", 64'(obs_waddr[42]), 10);
        check_eq("a52_wdata", 64'(obs_wdata[42]), 42);
        check_eq("b36_we", 64'(obs_we[94]), 64'hA);
        check_eq("b36_waddr", 64'(obs_waddr[94]), 46);
        check_eq("b36_wdata", 64'(obs_wdata[94]), 94);
        check_eq("b00_we", 64'(obs_we[64]), 64'h5);
        check_eq("b00_waddr", 64'(obs_waddr[64]), 32);

        for (int i = 0; i < 1024; i++) mem[i] = W'($urandom);

        // Back-to-back start, plus a start while busy that must be ignored.
        run_test(10'd200, 10'd500, 2, 1'b1);
        run_test(10'd100, 10'd300, 1, 1'b0);
        idle_ticks(1);

        // Address wrap at the top of shared memory.
        run_test(10'd1020, 10'd1010, 0, 1'b0);
        wrap_exp = '{10'd1020, 10'd1021, 10'd1022, 10'd1023, 10'd0, 10'd1};
        for (int i = 0; i < 6; i++) check_eq("wrap_addr", 64'(obs_raddr[i]), 64'(wrap_exp[i]));
        idle_ticks(2);

        for (int k = 0; k < 2; k++) begin
            run_test(L'($urandom), L'($urandom), 2, 1'b0);
            idle_ticks(1);
        end

        // Reset in the middle of a run: in-flight data must not be written.
        build_expect(10'd16, 10'd700);
        ab_v = 10'd16;
        bb_v = 10'd700;
        tick(1'b1, 1'b1);
        for (int i = 0; i < 40; i++) tick(1'b0, 1'b1);
        rst_v = 1'b1;
        tick(1'b0, 1'b1);
        exp_we_q.delete(); exp_waddr_q.delete(); exp_data_q.delete(); exp_raddr_q.delete();
        tick(1'b0, 1'b1);
        rst_v = 1'b0;
        tick(1'b0, 1'b1);
        check_eq("midrst_busy", 64'(bus.busy), 0);
        check_eq("midrst_rd", 64'(bus.mem_rd), 0);
        check_eq("midrst_we", 64'(bus.pim_we), 0);
        idle_ticks(8);

        run_test(10'd5, 10'd77, 0, 1'b0);
        idle_ticks(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
